mcycle_unit: RTL and testbench
==============================

// Module: mcycle_unit
// PURPOSE
//  Iterative multi-cycle multiply/divide unit in the Execute stage. Its Busy output
//  drives the hazard unit's M_BusyE input, which stalls F/D/E and flushes M.
//  Result1/Result2 feed the E-stage result mux. Busy is asserted in the Start cycle,
//  so the issuing instruction is held in E until results are ready.
// PARAMETERS
//  WIDTH  32  operand and result width in bits (even, >= 4)
// PORTS
//  CLK       in   1      clock; all state updates on rising edge
//  RESET     in   1      synchronous, active-high reset
//  Start     in   1      multi-cycle instruction is present in E (level, held during stall)
//  MCycleOp  in   2      [0]: 0=multiply, 1=divide; [1]: 0=signed, 1=unsigned
//  Operand1  in   WIDTH  multiplicand / dividend
//  Operand2  in   WIDTH  multiplier / divisor
//  Result1   out  WIDTH  mul: product[WIDTH-1:0]; div: quotient
//  Result2   out  WIDTH  mul: product[2*WIDTH-1:WIDTH]; div: remainder
//  Busy      out  1      stall request to hazard unit
// BEHAVIOUR
//  - Reset (RESET=1 at a clock edge): state=IDLE, Result1=Result2=0, count=0, Busy=0.
//    Reset overrides Start and aborts any operation in progress; partial results are discarded.
//  - States: IDLE, COMPUTING, DONE.
//    IDLE:      Busy = Start (combinational). If Start=1: latch operand magnitudes, signs, op;
//               count=0; go to COMPUTING.
//    COMPUTING: Busy=1. One iteration per cycle; count++. After WIDTH iterations
//               (count==WIDTH-1 at edge): apply sign fix-up, register Result1/2, go to DONE.
//    DONE:      Busy=0, results stable. Start is ignored (the pipeline advances this cycle).
//               Next cycle go to IDLE.
//  - Busy is high for exactly WIDTH+1 cycles (Start cycle + WIDTH COMPUTING cycles).
//    Results are valid from the first DONE cycle and held until the next completion or reset.
//  - Multiply: unsigned shift-add on magnitudes; 2*WIDTH-bit accumulator. Signed mode
//    negates the 2*WIDTH-bit product if operand signs differ. Unsigned uses raw operands.
//  - Divide: restoring shift-subtract on magnitudes. Signed: quotient negative iff signs
//    differ; remainder takes the dividend's sign (truncating division).
//  - Divide by zero: Result1 = all ones, Result2 = Operand1 (original value); the full
//    latency still applies.
//  - Signed overflow (most-negative / -1): Result1 = most-negative, Result2 = 0
//    (natural truncation of the magnitude datapath).
//  - Operands are sampled only in the IDLE Start cycle; later changes are ignored.
//  - Start falling during COMPUTING (e.g. instruction flushed) does not abort; the
//    operation completes normally.
// CONFIGURATION
//  MCYCLE_EARLY_TERM_EN
//   - Defined: multiply only. In COMPUTING, when the remaining unshifted multiplier bits
//     are all zero, finish that cycle: finish and go to DONE. At least 1 COMPUTING cycle;
//     results are identical to the full run. Divide is unaffected.
//   - Undefined: fixed latency of WIDTH COMPUTING cycles for all ops.
// TESTING (WIDTH=32, macro undefined unless stated)
//  1. mul unsigned 7*6 -> Result1=42, Result2=0; Busy high 33 cycles, then DONE with Busy=0.
//  2. mul signed -3*5 -> Result1=0xFFFFFFF1, Result2=0xFFFFFFFF.
//  3. div signed -7/2 -> Result1=0xFFFFFFFD, Result2=0xFFFFFFFF.
//     div unsigned 100/7 -> Result1=14, Result2=2.
//  4. div 0x1234/0 -> Result1=0xFFFFFFFF, Result2=0x00001234, latency 33.
//  5. RESET at COMPUTING cycle 10 -> next cycle Busy=0, Results=0.
//     Start held high -> new op begins (Busy=1 in that cycle).
//  6. Start held through DONE -> exactly one operation; Busy=0 in DONE, then Busy=1
//     re-asserts only in IDLE.
//     With MCYCLE_EARLY_TERM_EN: 5*3 unsigned -> DONE after 2 COMPUTING cycles, Result1=15.

Source files
------------

// File: rtl/mcycle_unit.sv
// rtl/mcycle_unit.sv - iterative multi-cycle multiply/divide unit for the Execute stage
//
// Purpose:
//   Radix-2 iterative multiplier (shift-add) and restoring divider (shift-subtract)
//   working on operand magnitudes, with a sign fix-up applied on the final iteration.
//   Busy stalls the pipeline from the Start cycle until results are registered.
//
// Ports:
//   CLK       in   1      clock, rising edge
//   RESET     in   1      synchronous active-high reset
//   Start     in   1      multi-cycle instruction present in E (level)
//   MCycleOp  in   2      [0] 0=mul 1=div, [1] 0=signed 1=unsigned
//   Operand1  in   WIDTH  multiplicand / dividend
//   Operand2  in   WIDTH  multiplier / divisor
//   Result1   out  WIDTH  mul: product low half, div: quotient
//   Result2   out  WIDTH  mul: product high half, div: remainder
//   Busy      out  1      stall request to the hazard unit
//
// Configuration macro:
//   MCYCLE_EARLY_TERM_EN - multiply finishes as soon as the remaining multiplier
//                          bits are all zero (at least one COMPUTING cycle).

module mcycle_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, COMPUTING, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      count;

  // Operation context captured in the Start cycle
  logic               op_div;
  logic               neg_q;      // negate product / quotient
  logic               neg_r;      // negate remainder (dividend sign)
  logic               div0;
  logic [WIDTH-1:0]   op1_raw;

  // Multiply datapath
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;

  // Divide datapath: quo starts as the dividend and is shifted out MSB-first
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   dvsr;

  logic [WIDTH-1:0]   mag1, mag2;
  logic               signed_op;

  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;
  logic               q_bit;
  logic [WIDTH-1:0]   rem_nxt, quo_nxt;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [WIDTH-1:0]   res1_fin, res2_fin;
  logic               finish;

  always_comb begin
    signed_op = ~MCycleOp[1];
    mag1 = (signed_op && Operand1[WIDTH-1]) ? -Operand1 : Operand1;
    mag2 = (signed_op && Operand2[WIDTH-1]) ? -Operand2 : Operand2;
  end

  // One iteration of both datapaths; only the one selected by op_div is used
  always_comb begin
    acc_nxt = mplier[0] ? (acc + mcand) : acc;

    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted - {1'b0, dvsr};
    q_bit   = ~diff[WIDTH];
    rem_nxt = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_nxt = {quo[WIDTH-2:0], q_bit};

    prod_fix = neg_q ? -acc_nxt : acc_nxt;
    quo_fix  = neg_q ? -quo_nxt : quo_nxt;
    rem_fix  = neg_r ? -rem_nxt : rem_nxt;

    if (op_div) begin
      res1_fin = div0 ? {WIDTH{1'b1}} : quo_fix;
      res2_fin = div0 ? op1_raw : rem_fix;
    end else begin
      res1_fin = prod_fix[WIDTH-1:0];
      res2_fin = prod_fix[2*WIDTH-1:WIDTH];
    end
  end

  always_comb begin
`ifdef MCYCLE_EARLY_TERM_EN
    // Bits above mplier[0] are the ones not yet consumed after this iteration
    finish = (count == CW'(WIDTH-1)) || (!op_div && (mplier[WIDTH-1:1] == '0));
`else
    finish = (count == CW'(WIDTH-1));
`endif
  end

  always_comb begin
    Busy = (state == COMPUTING) || ((state == IDLE) && Start);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      count   <= '0;
      Result1 <= '0;
      Result2 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            op_div  <= MCycleOp[0];
            neg_q   <= signed_op && (Operand1[WIDTH-1] ^ Operand2[WIDTH-1]);
            neg_r   <= signed_op && Operand1[WIDTH-1];
            div0    <= (Operand2 == '0);
            op1_raw <= Operand1;
            acc     <= '0;
            mcand   <= {{WIDTH{1'b0}}, mag1};
            mplier  <= mag2;
            rem     <= '0;
            quo     <= mag1;
            dvsr    <= mag2;
            count   <= '0;
            state   <= COMPUTING;
          end
        end
        COMPUTING: begin
          count  <= count + CW'(1);
          acc    <= acc_nxt;
          mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
          mplier <= {1'b0, mplier[WIDTH-1:1]};
          rem    <= rem_nxt;
          quo    <= quo_nxt;
          if (finish) begin
            Result1 <= res1_fin;
            Result2 <= res2_fin;
            state   <= DONE;
          end
        end
        DONE: begin
          // Start is ignored here: the pipeline advances past the instruction now
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcycle_unit.sv
// tb/tb_mcycle_unit.sv - directed vector bench for mcycle_unit

module tb_mcycle_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        Start;
  logic [1:0]  MCycleOp;
  logic [31:0] Operand1, Operand2;
  logic [31:0] Result1, Result2;
  logic        Busy;

  int tests = 0;
  int fails = 0;

  localparam logic [1:0] MUL_S = 2'b00;
  localparam logic [1:0] DIV_S = 2'b01;
  localparam logic [1:0] MUL_U = 2'b10;
  localparam logic [1:0] DIV_U = 2'b11;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r1;
    logic [31:0] r2;
    int          lat;
  } vec_t;

  mcycle_unit #(.WIDTH(32)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .Start    (Start),
    .MCycleOp (MCycleOp),
    .Operand1 (Operand1),
    .Operand2 (Operand2),
    .Result1  (Result1),
    .Result2  (Result2),
    .Busy     (Busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Counts negedges with Busy high, starting from an already-sampled Busy-high cycle
  task automatic wait_idle(inout int n);
    for (int g = 0; g < 200 && Busy; g++) begin
      n++;
      @(negedge CLK); #1;
    end
    if (Busy) chk("busy_timeout", 32'(Busy), 32'd0);
  endtask

  // Runs one operation; drops Start and scrambles operands after the Start cycle
  task automatic run_vec(input vec_t v, input int idx);
    int n;
    @(negedge CLK);
    Start = 1'b1; MCycleOp = v.op; Operand1 = v.a; Operand2 = v.b;
    #1;
    chk($sformatf("v%0d_busy_start", idx), 32'(Busy), 32'd1);
    n = 1;
    @(negedge CLK);
    Start = 1'b0; MCycleOp = ~v.op; Operand1 = ~v.a; Operand2 = ~v.b;
    #1;
    wait_idle(n);
    chk($sformatf("v%0d_result1", idx), Result1, v.r1);
    chk($sformatf("v%0d_result2", idx), Result2, v.r2);
`ifdef MCYCLE_EARLY_TERM_EN
    if (v.op[0]) chk($sformatf("v%0d_latency", idx), 32'(n), 32'(v.lat));
`else
    chk($sformatf("v%0d_latency", idx), 32'(n), 32'(v.lat));
`endif
  endtask

  vec_t vecs[12];

  initial begin
    int n;

    vecs[0]  = '{MUL_U, 32'd7,        32'd6,        32'd42,       32'd0,        33};
    vecs[1]  = '{MUL_S, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 32'hFFFFFFFF, 33};
    vecs[2]  = '{MUL_U, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 33};
    vecs[3]  = '{MUL_S, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 33};
    vecs[4]  = '{MUL_S, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 33};
    vecs[5]  = '{DIV_S, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 33};
    vecs[6]  = '{DIV_U, 32'd100,      32'd7,        32'd14,       32'd2,        33};
    vecs[7]  = '{DIV_U, 32'h00001234, 32'd0,        32'hFFFFFFFF, 32'h00001234, 33};
    vecs[8]  = '{DIV_S, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 33};
    vecs[9]  = '{DIV_S, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        33};
    vecs[10] = '{DIV_U, 32'hFFFFFFFF, 32'd2,        32'h7FFFFFFF, 32'd1,        33};
    vecs[11] = '{DIV_S, 32'hFFFFEDCC, 32'd0,        32'hFFFFFFFF, 32'hFFFFEDCC, 33};

    RESET = 1'b1; Start = 1'b0; MCycleOp = 2'b00; Operand1 = '0; Operand2 = '0;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    #1;
    chk("reset_busy", 32'(Busy), 32'd0);
    chk("reset_result1", Result1, 32'd0);
    chk("reset_result2", Result2, 32'd0);

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Reset partway through COMPUTING discards the operation and clears results
    @(negedge CLK);
    Start = 1'b1; MCycleOp = DIV_U; Operand1 = 32'd1000; Operand2 = 32'd3;
    repeat (11) @(negedge CLK);
    #1;
    chk("rst_mid_busy_before", 32'(Busy), 32'd1);
    Start = 1'b0; RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(Busy), 32'd0);
    chk("rst_mid_result1", Result1, 32'd0);
    chk("rst_mid_result2", Result2, 32'd0);
    Start = 1'b1; MCycleOp = DIV_U; Operand1 = 32'd100; Operand2 = 32'd7;
    #1;
    chk("rst_restart_busy", 32'(Busy), 32'd1);
    n = 1;
    @(negedge CLK); #1;
    wait_idle(n);
    chk("rst_restart_result1", Result1, 32'd14);
    chk("rst_restart_result2", Result2, 32'd2);
    chk("rst_restart_latency", 32'(n), 32'd33);
    Start = 1'b0;

    // Start held through DONE: one op completes, DONE drops Busy, IDLE re-issues
    @(negedge CLK);
    Start = 1'b1; MCycleOp = MUL_U; Operand1 = 32'd7; Operand2 = 32'd6;
    #1;
    n = 1;
    @(negedge CLK); #1;
    wait_idle(n);
    chk("hold_done_busy", 32'(Busy), 32'd0);
    chk("hold_result1", Result1, 32'd42);
    @(negedge CLK); #1;
    chk("hold_reissue_busy", 32'(Busy), 32'd1);
    chk("hold_result1_kept", Result1, 32'd42);
    n = 1;
    @(negedge CLK); #1;
    wait_idle(n);
    chk("hold_second_result1", Result1, 32'd42);
    chk("hold_second_result2", Result2, 32'd0);
    Start = 1'b0;
    @(negedge CLK); #1;
    chk("hold_idle_busy", 32'(Busy), 32'd0);

`ifdef MCYCLE_EARLY_TERM_EN
    @(negedge CLK);
    Start = 1'b1; MCycleOp = MUL_U; Operand1 = 32'd5; Operand2 = 32'd3;
    #1;
    n = 1;
    @(negedge CLK);
    Start = 1'b0;
    #1;
    wait_idle(n);
    chk("et_result1", Result1, 32'd15);
    chk("et_result2", Result2, 32'd0);
    chk("et_latency", 32'(n), 32'd3);
`endif

    repeat (2) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
